bus_slave_tgt: RTL
==================

# bus_slave_tgt

Bus slave target stage sitting directly downstream of a slave port of the 4-master/4-slave arbiter. It accepts one request at a time and decodes it against its own 256-byte address window. It services hits from a 64-word register file with programmable read wait states and returns a response through a valid/ready handshake. It also keeps per-master saturating read and write counts for end-of-run reporting.

## Interface
- SLV_ID, 4'h0: slave number; selects the window FFEF_S200–FFEF_S2FF, where S = SLV_ID.
- WAIT, 2: read wait states, 0..15.
- NMSTR, 4: number of masters; master ID width is 2.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready; a request is accepted in a cycle where req_vld && req_rdy.
- req_addr  in  32  byte address.
- req_wr  in  1  1 = write, 0 = read.
- req_wdata  in  32  write data.
- req_mid  in  2  ID of the issuing master.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response ready.
- rsp_rdata  out  32  read data; 0 for writes and for errors.
- rsp_err  out  1  decode or alignment error.
- cnt_sel  in  2  master selected for the counter outputs.
- rd_cnt  out  20  read count of master cnt_sel (combinational mux).
- wr_cnt  out  20  write count of master cnt_sel (combinational mux).

## Operation
- Hit condition, all of:
  - addr[31:16] = 16'hFFEF
  - addr[15:12] = SLV_ID
  - addr[11:8] = 4'h2
  - addr[1:0] = 2'b00
- Word index is addr[7:2] (64 words).
- A miss or misaligned address sets rsp_err = 1:
  - no memory access
  - rsp_rdata = 0
  - no counter update
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_rdy = 1.
  - On accept, capture wr, mid, index and err.
  - A write hit commits to memory on the accept edge; next state is RESP.
  - A read hit goes to WAIT with wcnt = WAIT-1, or directly to RESP if WAIT = 0.
  - Any error goes directly to RESP.
- WAIT:
  - req_rdy = 0.
  - Decrement wcnt; go to RESP when wcnt = 0.
- RESP:
  - rsp_vld = 1.
  - Read data is registered from memory on entry to RESP.
  - rsp_rdata and rsp_err hold stable until rsp_rdy.
  - On handshake, go to IDLE.
- Exactly one transaction is outstanding at a time; req_rdy = 0 outside IDLE.
- Counters:
  - One 20-bit counter per master per type.
  - Incremented on the response handshake of a non-error transaction.
  - Saturate at 20'hFFFFF; no wrap.
- Reset behaviour:
  - state = IDLE, req_rdy = 1, rsp_vld = 0, rsp_rdata = 0, rsp_err = 0.
  - All memory words = 0; all counters = 0.
- Reset mid-transaction drops the transaction with no response; a write already committed remains until the memory is cleared by that same reset.

## Timing
- Write or error accepted at cycle T: rsp_vld is asserted at T+1.
- Read hit accepted at T: rsp_vld is asserted at T+1+WAIT.
- Response handshake at cycle R: req_rdy = 1 at R+1. There is no same-cycle re-accept, so throughput is at most one transaction per 2 cycles.
- Read-after-write to the same word returns the new data, because the write commits before RESP.
- rsp_rdy held high before rsp_vld: the handshake completes in the first RESP cycle.
- rd_cnt and wr_cnt reflect an increment in the cycle after the handshake.

## Structure
- Package bus_pkg contains:
  - tgt_state_e {IDLE, WAIT, RESP}
  - BASE_HI = 16'hFFEF
  - WIN_SEL = 4'h2
  - CNT_W = 20
  - MID_W = 2
  - MEM_WORDS = 64
- Sub-module bus_sat_cnt: 20-bit saturating counter with inc and synchronous clr. It is instantiated 2×NMSTR times.
- The rest is flat: FSM, decode, memory array and output mux.

## Test plan
- Write then read, SLV_ID = 1, WAIT = 2:
  - Write 0xDEADBEEF to FFEF_1204 → rsp_vld at T+1 with err = 0.
  - Read FFEF_1204 → rsp_vld at T+3 with rdata = 0xDEADBEEF.
  - With cnt_sel = mid: wr_cnt = 1, rd_cnt = 1.
- Decode errors:
  - Read FFEF_2204, a different slave → err = 1, rdata = 0, counters unchanged.
  - Write FFEF_1206, misaligned → err = 1, memory at word 1 unchanged.
- Backpressure: hold rsp_rdy = 0 for 5 cycles → rsp_vld stays 1, rdata stable, req_rdy = 0 throughout, counter increments only after rsp_rdy.
- Per-master counters and WAIT = 0: masters 0–3 issue 1, 2, 3 and 4 reads respectively → rd_cnt = 1, 2, 3, 4 via cnt_sel; each read latency is 1 cycle.
- Saturation: force a counter to 20'hFFFFE, then complete 3 writes → wr_cnt = 20'hFFFFF.
- Reset mid-read: assert rst during WAIT → next cycle rsp_vld = 0, req_rdy = 1, and a read of a previously written word returns 0.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the bus slave target
// Purpose: FSM state type, address window constants and sizing for bus_slave_tgt.
// Ports: none (package).
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } tgt_state_e;

  localparam logic [15:0] BASE_HI   = 16'hFFEF;
  localparam logic [3:0]  WIN_SEL   = 4'h2;
  localparam int          CNT_W     = 20;
  localparam int          MID_W     = 2;
  localparam int          MEM_WORDS = 64;

endpackage

// File: rtl/bus_sat_cnt.sv
// rtl/bus_sat_cnt.sv - saturating event counter
// Purpose: counts inc pulses, sticks at all-ones instead of wrapping.
// Ports: clk_i clock, clr_i synchronous clear, inc_i count enable, cnt_o count value.
module bus_sat_cnt
  import bus_pkg::*;
(
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bus_slave_tgt.sv
// rtl/bus_slave_tgt.sv - single-outstanding bus slave with register file and per-master counters
// Purpose: decodes a 256-byte window, serves a 64-word register file with read wait
//   states, answers over a valid/ready response channel, counts reads/writes per master.
// Ports: clk/rst clock and sync active-high reset; req_* request channel (vld/rdy,
//   addr, wr, wdata, mid); rsp_* response channel (vld/rdy, rdata, err);
//   cnt_sel selects the master whose rd_cnt/wr_cnt are shown.
module bus_slave_tgt #(
  parameter logic [3:0]  SLV_ID = 4'h0,
  parameter int unsigned WAIT   = 2,
  parameter int unsigned NMSTR  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_vld,
  output logic                      req_rdy,
  input  logic [31:0]               req_addr,
  input  logic                      req_wr,
  input  logic [31:0]               req_wdata,
  input  logic [bus_pkg::MID_W-1:0] req_mid,
  output logic                      rsp_vld,
  input  logic                      rsp_rdy,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  input  logic [bus_pkg::MID_W-1:0] cnt_sel,
  output logic [bus_pkg::CNT_W-1:0] rd_cnt,
  output logic [bus_pkg::CNT_W-1:0] wr_cnt
);

  import bus_pkg::*;

  // WAIT names the wait-state parameter here, so states are always package-qualified.
  bus_pkg::tgt_state_e state_q;

  logic             req_rdy_q;
  logic             rsp_vld_q;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic             wr_q;
  logic [MID_W-1:0] mid_q;
  logic [5:0]       idx_q;
  logic [3:0]       wcnt_q;
  logic [31:0]      mem_q [MEM_WORDS];

  logic       hit;
  logic [5:0] idx;
  logic       accept;
  logic       rsp_hs;

  assign hit = (req_addr[31:16] == BASE_HI) && (req_addr[15:12] == SLV_ID) &&
               (req_addr[11:8] == WIN_SEL) && (req_addr[1:0] == 2'b00);
  assign idx    = req_addr[7:2];
  assign accept = req_rdy_q && req_vld;   // req_rdy_q is high only in IDLE
  assign rsp_hs = rsp_vld_q && rsp_rdy;   // rsp_vld_q is high only in RESP

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= bus_pkg::IDLE;
      req_rdy_q <= 1'b1;
      rsp_vld_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      mid_q     <= '0;
      idx_q     <= '0;
      wcnt_q    <= '0;
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        bus_pkg::IDLE: begin
          if (accept) begin
            wr_q      <= req_wr;
            mid_q     <= req_mid;
            idx_q     <= idx;
            err_q     <= !hit;
            rdata_q   <= '0;
            req_rdy_q <= 1'b0;
            if (hit && req_wr) begin
              mem_q[idx] <= req_wdata;
              state_q    <= bus_pkg::RESP;
              rsp_vld_q  <= 1'b1;
            end else if (hit && (WAIT != 0)) begin
              wcnt_q  <= 4'(WAIT - 1);
              state_q <= bus_pkg::WAIT;
            end else begin
              // Zero-wait read hit samples memory here; errors leave rdata at 0.
              if (hit) begin
                rdata_q <= mem_q[idx];
              end
              state_q   <= bus_pkg::RESP;
              rsp_vld_q <= 1'b1;
            end
          end
        end
        bus_pkg::WAIT: begin
          if (wcnt_q == 4'd0) begin
            rdata_q   <= mem_q[idx_q];
            state_q   <= bus_pkg::RESP;
            rsp_vld_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        bus_pkg::RESP: begin
          if (rsp_rdy) begin
            state_q   <= bus_pkg::IDLE;
            rsp_vld_q <= 1'b0;
            req_rdy_q <= 1'b1;
            rdata_q   <= '0;
            err_q     <= 1'b0;
          end
        end
        default: begin
          state_q   <= bus_pkg::IDLE;
          rsp_vld_q <= 1'b0;
          req_rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_rdy   = req_rdy_q;
  assign rsp_vld   = rsp_vld_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  logic [CNT_W-1:0] rd_cnt_w [NMSTR];
  logic [CNT_W-1:0] wr_cnt_w [NMSTR];

  for (genvar m = 0; m < NMSTR; m++) begin : g_cnt
    logic done;
    assign done = rsp_hs && !err_q && (mid_q == MID_W'(m));

    bus_sat_cnt u_rd (
      .clk_i (clk),
      .clr_i (rst),
      .inc_i (done && !wr_q),
      .cnt_o (rd_cnt_w[m])
    );

    bus_sat_cnt u_wr (
      .clk_i (clk),
      .clr_i (rst),
      .inc_i (done && wr_q),
      .cnt_o (wr_cnt_w[m])
    );
  end

  always_comb begin
    rd_cnt = '0;
    wr_cnt = '0;
    if (32'(cnt_sel) < NMSTR) begin
      rd_cnt = rd_cnt_w[cnt_sel];
      wr_cnt = wr_cnt_w[cnt_sel];
    end
  end

endmodule
